// File: rtl/counter_timer_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_timer_arbiter_pkg
// Description : Shared state encodings, default widths and helpers for the
//               counter/timer arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_timer_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int C_DEFAULT_CW = 8;

    // Constant-evaluable ceil(log2(value)); returns 1 for value <= 2.
    function automatic int clog2_f(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/counter_timer_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker; searches upward from ptr_i
//               with wrap, returns one-hot grant and its encoded index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import counter_timer_arbiter_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = clog2_f(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic [IW:0] pos;
    logic        found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = 0; i < N; i++) begin
            // Modulo-N wrap without a divider; N need not be a power of two.
            pos = {1'b0, ptr_i} + (IW+1)'(i);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            if (!found && req_i[pos[IW-1:0]]) begin
                found              = 1'b1;
                gnt_o[pos[IW-1:0]] = 1'b1;
                idx_o              = pos[IW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/counter_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : counter_timer_arbiter
// Description : One down-counting delay timer shared by N_REQ requesters via
//               round-robin arbitration, with cancel and a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_timer_arbiter
    import counter_timer_arbiter_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int CW    = C_DEFAULT_CW,
    localparam int IW    = clog2_f(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid_i,
    input  logic [N_REQ*CW-1:0] req_delay_i,
    input  logic [N_REQ-1:0]    cancel_i,
    output logic [N_REQ-1:0]    req_ready_o,
    output logic [N_REQ-1:0]    done_o,
    output logic                busy_o,
    output logic [IW-1:0]       grant_id_o,
    output logic [CW-1:0]       count_out_o
);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]      grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [N_REQ-1:0]   arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic [CW-1:0]      arb_delay;

    rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    always_comb begin
        arb_delay = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                arb_delay = req_delay_i[i*CW +: CW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        done_d      = '0;
        req_ready_o = '0;
        case (state_q)
            ST_IDLE: begin
                // Accept and load happen on the same edge.
                if (|req_valid_i) begin
                    req_ready_o = arb_gnt;
                    cnt_d       = arb_delay;
                    grant_d     = arb_idx;
                    rr_ptr_d    = (arb_idx == IW'(N_REQ-1)) ? '0 : arb_idx + IW'(1);
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cancel_i[grant_q]) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    done_d[grant_q] = 1'b1;
                    state_d         = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
        end
    end

    assign done_o      = done_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign grant_id_o  = grant_q;
    assign count_out_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_timer_arbiter
// Description : Self-checking bench for counter_timer_arbiter: arbitration
//               table plus directed cancel, max-delay and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_timer_arbiter;

    localparam int N  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  cancel;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  done;
    logic          busy;
    logic [1:0]    grant_id;
    logic [CW-1:0] count_out;
    logic [CW-1:0] dly [N];
    logic [N*CW-1:0] req_delay;

    assign req_delay = {dly[3], dly[2], dly[1], dly[0]};

    always #5 clk = ~clk;

    counter_timer_arbiter #(.N_REQ(N), .CW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_delay_i (req_delay),
        .cancel_i    (cancel),
        .req_ready_o (req_ready),
        .done_o      (done),
        .busy_o      (busy),
        .grant_id_o  (grant_id),
        .count_out_o (count_out)
    );

    typedef struct {
        int id;
        int cyc;
    } exp_t;

    typedef struct {
        logic [N-1:0]  valid;
        logic [CW-1:0] delay;
        int            exp_id;
        int            exp_gap;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[9];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   acc_id = 0;
    int   acc_cyc = 0;
    int   prev_k = 0;
    bit   acc_flag = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_done();
        exp_t e;
        if (done !== '0) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL done_unexpected: got done=%b, expected none (cycle %0d)", done, cyc);
            end else begin
                e = sb.pop_front();
                chk("done_onehot", 32'(done), 32'(1) << e.id);
                chk("done_cycle", cyc, e.cyc);
            end
        end
        if (sb.size() > 0 && cyc > sb[0].cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_missing: got no done, expected done[%0d] at cycle %0d (now %0d)",
                     sb[0].id, sb[0].cyc, cyc);
            void'(sb.pop_front());
        end
    endtask

    // Called at posedge+2; samples combinational ready, advances one cycle.
    task automatic step();
        exp_t e;
        #1;
        acc_flag = 1'b0;
        if (req_ready !== '0) begin
            n_tests++;
            if (!$onehot(req_ready) || busy || ((req_ready & ~req_valid) != '0)) begin
                n_fail++;
                $display("FAIL ready_legal: got ready=%b busy=%b, expected one-hot in IDLE within valid=%b",
                         req_ready, busy, req_valid);
            end else begin
                acc_flag = 1'b1;
                for (int i = 0; i < N; i++) begin
                    if (req_ready[i]) acc_id = i;
                end
                acc_cyc = cyc;
                e.id  = acc_id;
                e.cyc = cyc + int'(dly[acc_id]) + 2;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        cyc++;
        #2;
        check_done();
    endtask

    task automatic wait_accept(input string name);
        acc_flag = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (acc_flag) break;
        end
        if (!acc_flag) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no accept, expected one within 60 cycles", name);
        end
    endtask

    task automatic wait_count(input string name, input logic [CW-1:0] target, input int bound);
        int i;
        i = 0;
        while (count_out !== target && i < bound) begin
            step();
            i++;
        end
        chk(name, 32'(count_out), 32'(target));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        cyc++;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{4'b1111, 8'd0, 0, -1};
        tbl[1] = '{4'b1111, 8'd0, 1, 3};
        tbl[2] = '{4'b1111, 8'd0, 2, 3};
        tbl[3] = '{4'b1111, 8'd0, 3, 3};
        tbl[4] = '{4'b1111, 8'd0, 0, 3};
        tbl[5] = '{4'b0101, 8'd0, 2, 3};
        tbl[6] = '{4'b0101, 8'd0, 0, 3};
        tbl[7] = '{4'b1010, 8'd2, 1, 3};
        tbl[8] = '{4'b1010, 8'd0, 3, 5};

        rst_n     = 1'b0;
        req_valid = '0;
        cancel    = '0;
        for (int i = 0; i < N; i++) dly[i] = '0;

        // Reset state
        #12;
        rst_n = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(count_out), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_grant", 32'(grant_id), 0);
        @(posedge clk);
        cyc++;
        #2;

        // Single request, delay 5
        dly[0]    = 8'd5;
        req_valid = 4'b0001;
        wait_accept("t2_accept");
        req_valid = '0;
        chk("t2_id", acc_id, 0);
        for (int i = 0; i < 6; i++) begin
            chk("t2_count", 32'(count_out), 32'(5 - i));
            chk("t2_busy_run", 32'(busy), 1);
            step();
        end
        chk("t2_busy_done", 32'(busy), 1);
        step();
        chk("t2_busy_low", 32'(busy), 0);
        chk("t2_latency", cyc - acc_cyc, 8);

        // Round-robin table from reset
        do_reset();
        for (int r = 0; r < 9; r++) begin
            req_valid = tbl[r].valid;
            for (int i = 0; i < N; i++) dly[i] = tbl[r].delay;
            wait_accept("t3_accept");
            chk("t3_ready_id", acc_id, tbl[r].exp_id);
            chk("t3_grant_id", 32'(grant_id), 32'(tbl[r].exp_id));
            if (tbl[r].exp_gap >= 0) chk("t3_gap", acc_cyc - prev_k, tbl[r].exp_gap);
            prev_k = acc_cyc;
        end
        req_valid = '0;
        for (int i = 0; i < 6; i++) step();

        // Cancel by owner 2; cancel[1] ignored
        dly[2]    = 8'd20;
        req_valid = 4'b0100;
        wait_accept("t4_accept");
        req_valid = '0;
        chk("t4_id", acc_id, 2);
        wait_count("t4_reach12", 8'd12, 40);
        cancel = 4'b0010;
        step();
        cancel = '0;
        chk("t4_foreign_cancel_count", 32'(count_out), 11);
        chk("t4_foreign_cancel_busy", 32'(busy), 1);
        step();
        chk("t4_count10", 32'(count_out), 10);
        cancel = 4'b0110;
        sb.delete();
        step();
        cancel = '0;
        chk("t4_cancel_busy", 32'(busy), 0);
        chk("t4_cancel_count", 32'(count_out), 0);
        for (int i = 0; i < 25; i++) step();

        // Cancel coinciding with count zero
        dly[0]    = 8'd3;
        req_valid = 4'b0001;
        wait_accept("t4b_accept");
        req_valid = '0;
        wait_count("t4b_reach0", 8'd0, 10);
        chk("t4b_still_running", 32'(busy), 1);
        cancel = 4'b0001;
        sb.delete();
        step();
        cancel = '0;
        chk("t4b_cancel_busy", 32'(busy), 0);
        for (int i = 0; i < 4; i++) step();

        // Maximum delay
        dly[0]    = 8'd255;
        req_valid = 4'b0001;
        wait_accept("t5_accept");
        req_valid = '0;
        chk("t5_load", 32'(count_out), 255);
        for (int i = 0; i < 256; i++) step();
        chk("t5_elapsed", cyc - acc_cyc, 257);
        chk("t5_no_wrap", 32'(count_out), 0);
        step();
        chk("t5_idle", 32'(busy), 0);

        // Asynchronous reset mid-run, requester still valid
        dly[0]    = 8'd60;
        req_valid = 4'b0001;
        wait_accept("t6_accept");
        wait_count("t6_reach40", 8'd40, 40);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_busy", 32'(busy), 0);
        chk("t6_async_count", 32'(count_out), 0);
        chk("t6_async_done", 32'(done), 0);
        sb.delete();
        @(posedge clk);
        cyc++;
        @(posedge clk);
        cyc++;
        #2;
        rst_n = 1'b1;
        wait_accept("t6_reaccept");
        req_valid = '0;
        chk("t6_regrant_id", acc_id, 0);
        chk("t6_restart_count", 32'(count_out), 60);
        for (int i = 0; i < 70; i++) step();
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
